qm_egress_sched: RTL and testbench

- Egress-side sequencer for the queue manager (qm).
- Pops one frame descriptor from qm's pointer FIFO and decodes destination port and byte length.
- Waits for that egress port to be ready, then drains exactly that many bytes from qm's data FIFO.
- Presents each frame on an egress stream (sof/dv/eof/data/port) with a programmable inter-frame gap.

---
 rtl/qm_egress_sched.sv | 208 ++++++++++++++++++++
 tb/tb_qm_egress_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qm_egress_sched.sv
// qm_egress_sched
// Egress-side sequencer for the queue manager. Pops one frame descriptor
// from qm's pointer FIFO, checks it, waits for the destination port to be
// ready, then drains exactly the frame's byte count from qm's data FIFO and
// presents the bytes on a sof/dv/eof stream. A fixed inter-frame gap follows
// each frame. Rejected descriptors are counted and skipped without touching
// the data FIFO.

module qm_egress_sched #(
  parameter int NPORTS = 16,  // egress ports, legal destinations 0..NPORTS-1 (max 16)
  parameter int LEN_W  = 12,  // width of the descriptor length field
  parameter int IFG    = 2    // idle cycles after each frame (0 allowed)
) (
  input  logic              clk,
  input  logic              rst,

  // qm pointer FIFO
  input  logic              ptr_fifo_empty,
  input  logic [15:0]       ptr_fifo_dout,
  output logic              ptr_fifo_rd,

  // qm data FIFO
  input  logic [7:0]        data_fifo_dout,
  output logic              data_fifo_rd,

  // egress MAC readiness
  input  logic [NPORTS-1:0] port_rdy,

  // egress stream
  output logic [3:0]        out_port,
  output logic              out_sof,
  output logic              out_dv,
  output logic              out_eof,
  output logic [7:0]        out_data,

  // status
  output logic              busy,
  output logic [15:0]       frm_cnt,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PTR_WAIT = 3'd1,
    ARB      = 3'd2,
    DATA     = 3'd3,
    TAIL     = 3'd4,
    GAP      = 3'd5
  } state_e;

  // Gap counter holds IFG-1 down to 0; it is never used when IFG is 0.
  localparam int               GAP_W    = (IFG > 1) ? $clog2(IFG) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IFG > 0) ? IFG - 1 : 0);
  localparam logic [4:0]       NPORTS_L = 5'(NPORTS);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  // State and registered outputs
  state_e           state_q,    state_d;
  logic [LEN_W-1:0] len_q,      len_d;
  logic [3:0]       port_q,     port_d;
  logic [LEN_W-1:0] cnt_q,      cnt_d;
  logic [GAP_W-1:0] gap_q,      gap_d;
  logic [3:0]       out_port_q, out_port_d;
  logic             sof_q,      sof_d;
  logic             dv_q,       dv_d;
  logic             eof_q,      eof_d;
  logic [15:0]      frm_q,      frm_d;
  logic [7:0]       err_q,      err_d;

  // Descriptor fields as they appear on the FIFO output during PTR_WAIT
  logic [LEN_W-1:0] desc_len;
  logic [3:0]       desc_port;
  logic             desc_bad;
  logic [15:0]      rdy_ext;

  assign desc_len  = ptr_fifo_dout[LEN_W-1:0];
  assign desc_port = ptr_fifo_dout[15:12];
  assign desc_bad  = (desc_len == '0) || ({1'b0, desc_port} >= NPORTS_L);

  // Zero-extend so any 4-bit port index selects a defined bit; ports
  // beyond NPORTS never reach ARB anyway.
  assign rdy_ext   = 16'(port_rdy);

  // Next-state and datapath decode for the frame sequencer
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    len_d      = len_q;
    port_d     = port_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    out_port_d = out_port_q;
    frm_d      = frm_q;
    err_d      = err_q;
    sof_d      = 1'b0;
    dv_d       = 1'b0;
    eof_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!ptr_fifo_empty) begin
          state_d = PTR_WAIT;
        end
      end

      PTR_WAIT: begin
        len_d  = desc_len;
        port_d = desc_port;
        if (desc_bad) begin
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          state_d = IDLE;
        end else begin
          out_port_d = desc_port;
          state_d    = ARB;
        end
      end

      ARB: begin
        if (rdy_ext[port_q]) begin
          cnt_d   = len_q;
          state_d = DATA;
        end
      end

      DATA: begin
        // Each read here shows up as a stream beat one cycle later.
        dv_d  = 1'b1;
        sof_d = (cnt_q == len_q);
        eof_d = (cnt_q == LEN_ONE);
        cnt_d = cnt_q - LEN_ONE;
        if (cnt_q == LEN_ONE) begin
          state_d = TAIL;
        end
      end

      TAIL: begin
        frm_d = frm_q + 16'd1;
        if (IFG > 0) begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          state_d = IDLE;
        end
      end

      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Register all state; synchronous reset returns to IDLE with everything cleared
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      port_q     <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      out_port_q <= '0;
      sof_q      <= 1'b0;
      dv_q       <= 1'b0;
      eof_q      <= 1'b0;
      frm_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      port_q     <= port_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      out_port_q <= out_port_d;
      sof_q      <= sof_d;
      dv_q       <= dv_d;
      eof_q      <= eof_d;
      frm_q      <= frm_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the FIFO strobes are decoded from the state flop rather than
  // registered: the descriptor must be on ptr_fifo_dout during PTR_WAIT and
  // DATA must read on its first cycle. Gating with rst stops any pop the
  // moment reset is applied, so an aborted frame leaves its bytes in qm.
  assign ptr_fifo_rd  = (state_q == IDLE) && !ptr_fifo_empty && !rst;
  assign data_fifo_rd = (state_q == DATA) && !rst;

  assign out_port = out_port_q;
  assign out_sof  = sof_q;
  assign out_dv   = dv_q;
  assign out_eof  = eof_q;
  assign out_data = dv_q ? data_fifo_dout : 8'h00;
  assign busy     = (state_q != IDLE);
  assign frm_cnt  = frm_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_qm_egress_sched.sv
// Directed bench for qm_egress_sched. Two instances: the default build
// (16 ports, IFG=2) for the streaming scenarios and a 2-port build for
// descriptor rejection. Small FIFO models stand in for qm.

module tb_qm_egress_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main instance
  logic        ptr_fifo_empty;
  logic [15:0] ptr_fifo_dout = '0;
  logic        ptr_fifo_rd;
  logic [7:0]  data_fifo_dout = '0;
  logic        data_fifo_rd;
  logic [15:0] port_rdy;
  logic [3:0]  out_port;
  logic        out_sof, out_dv, out_eof;
  logic [7:0]  out_data;
  logic        busy;
  logic [15:0] frm_cnt;
  logic [7:0]  err_cnt;

  qm_egress_sched #(.NPORTS(16), .LEN_W(12), .IFG(2)) dut (
    .clk(clk), .rst(rst),
    .ptr_fifo_empty(ptr_fifo_empty), .ptr_fifo_dout(ptr_fifo_dout), .ptr_fifo_rd(ptr_fifo_rd),
    .data_fifo_dout(data_fifo_dout), .data_fifo_rd(data_fifo_rd),
    .port_rdy(port_rdy),
    .out_port(out_port), .out_sof(out_sof), .out_dv(out_dv), .out_eof(out_eof), .out_data(out_data),
    .busy(busy), .frm_cnt(frm_cnt), .err_cnt(err_cnt)
  );

  // Two-port instance for out-of-range destinations
  logic        ptr_fifo_empty_b;
  logic [15:0] ptr_fifo_dout_b = '0;
  logic        ptr_fifo_rd_b;
  logic [7:0]  data_fifo_dout_b;
  logic        data_fifo_rd_b;
  logic [1:0]  port_rdy_b;
  logic [3:0]  out_port_b;
  logic        out_sof_b, out_dv_b, out_eof_b;
  logic [7:0]  out_data_b;
  logic        busy_b;
  logic [15:0] frm_cnt_b;
  logic [7:0]  err_cnt_b;

  assign data_fifo_dout_b = 8'h00;

  qm_egress_sched #(.NPORTS(2), .LEN_W(12), .IFG(2)) dut_b (
    .clk(clk), .rst(rst),
    .ptr_fifo_empty(ptr_fifo_empty_b), .ptr_fifo_dout(ptr_fifo_dout_b), .ptr_fifo_rd(ptr_fifo_rd_b),
    .data_fifo_dout(data_fifo_dout_b), .data_fifo_rd(data_fifo_rd_b),
    .port_rdy(port_rdy_b),
    .out_port(out_port_b), .out_sof(out_sof_b), .out_dv(out_dv_b), .out_eof(out_eof_b), .out_data(out_data_b),
    .busy(busy_b), .frm_cnt(frm_cnt_b), .err_cnt(err_cnt_b)
  );

  // qm FIFO models: read data appears the cycle after the strobe
  logic [15:0] ptr_mem [0:63];
  logic [7:0]  dat_mem [0:255];
  logic [15:0] ptr_mem_b [0:511];
  int ptr_wr = 0, ptr_rdi = 0;
  int dat_wr = 0, dat_rdi = 0;
  int ptr_wr_b = 0, ptr_rdi_b = 0;

  assign ptr_fifo_empty   = (ptr_rdi == ptr_wr);
  assign ptr_fifo_empty_b = (ptr_rdi_b == ptr_wr_b);

  always @(posedge clk) begin
    if (ptr_fifo_rd) begin
      ptr_fifo_dout <= ptr_mem[ptr_rdi];
      ptr_rdi       <= ptr_rdi + 1;
    end
    if (data_fifo_rd) begin
      data_fifo_dout <= (dat_rdi < dat_wr) ? dat_mem[dat_rdi] : 8'hEE;
      dat_rdi        <= dat_rdi + 1;
    end
    if (ptr_fifo_rd_b) begin
      ptr_fifo_dout_b <= ptr_mem_b[ptr_rdi_b];
      ptr_rdi_b       <= ptr_rdi_b + 1;
    end
  end

  // Stream monitor, sampled mid-cycle
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] beat_data [$];
  logic       beat_sof  [$];
  logic       beat_eof  [$];
  int         pop_cyc   [$];
  int         rd_start  [$];
  int         eof_cyc   [$];
  int         rd_cnt = 0;
  logic       rd_prev = 1'b0;
  int         rd_cnt_b = 0;
  int         pop_cnt_b = 0;

  always @(negedge clk) begin
    if (ptr_fifo_rd) pop_cyc.push_back(cyc);
    if (data_fifo_rd) begin
      rd_cnt++;
      if (!rd_prev) rd_start.push_back(cyc);
    end
    rd_prev = data_fifo_rd;
    if (out_dv) begin
      beat_data.push_back(out_data);
      beat_sof.push_back(out_sof);
      beat_eof.push_back(out_eof);
      if (out_eof) eof_cyc.push_back(cyc);
    end
    if (data_fifo_rd_b) rd_cnt_b++;
    if (ptr_fifo_rd_b)  pop_cnt_b++;
  end

  // Checking
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_ptr(input logic [15:0] d);
    ptr_mem[ptr_wr] = d;
    ptr_wr++;
  endtask

  task automatic push_dat(input logic [7:0] d);
    dat_mem[dat_wr] = d;
    dat_wr++;
  endtask

  task automatic push_ptr_b(input logic [15:0] d);
    ptr_mem_b[ptr_wr_b] = d;
    ptr_wr_b++;
  endtask

  // Bounded wait for the main instance's frame counter
  task automatic wait_frm(input string tag, input logic [15:0] target, input int budget);
    int n = 0;
    while (frm_cnt !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, frm_cnt, target);
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int base, rd0, np, nr, ne, n;
    logic [7:0] e;

    rst        = 1'b1;
    port_rdy   = 16'h0002;
    port_rdy_b = 2'b11;

    // Single frame queued before reset: port 1, 34 bytes
    push_dat(8'h01);
    push_dat(8'h32);
    for (int i = 2; i <= 33; i++) push_dat(8'(i));
    push_ptr(16'h1022);

    // Reset held 3 cycles with a descriptor waiting
    repeat (3) begin
      @(negedge clk);
      check("rst_ptr_rd", ptr_fifo_rd, 0);
    end
    check("rst_data_rd", data_fifo_rd, 0);
    check("rst_dv",      out_dv, 0);
    check("rst_sof",     out_sof, 0);
    check("rst_eof",     out_eof, 0);
    check("rst_data",    out_data, 0);
    check("rst_port",    out_port, 0);
    check("rst_busy",    busy, 0);
    check("rst_frm",     frm_cnt, 0);
    check("rst_err",     err_cnt, 0);
    check("rst_err_b",   err_cnt_b, 0);

    drive_slot();
    rst  = 1'b0;
    base = beat_data.size();
    rd0  = rd_cnt;
    wait_frm("f1_done", 16'd1, 120);
    check("f1_beats", beat_data.size() - base, 34);
    check("f1_reads", rd_cnt - rd0, 34);
    if (beat_data.size() - base == 34) begin
      for (int i = 0; i < 34; i++) begin
        e = (i == 0) ? 8'h01 : (i == 1) ? 8'h32 : 8'(i);
        check("f1_byte", beat_data[base+i], e);
        check("f1_sof",  beat_sof[base+i], (i == 0)  ? 1 : 0);
        check("f1_eof",  beat_eof[base+i], (i == 33) ? 1 : 0);
      end
    end
    check("f1_port", out_port, 1);
    check("f1_err",  err_cnt, 0);
    repeat (5) @(negedge clk);
    check("f1_idle", busy, 0);

    // Backpressure: port 3 held not-ready, then released
    drive_slot();
    port_rdy = 16'h0000;
    for (int i = 0; i < 5; i++) push_dat(8'hA0 + 8'(i));
    push_ptr(16'h3005);
    base = beat_data.size();
    rd0  = rd_cnt;
    repeat (12) @(negedge clk);
    check("bp_no_rd",  rd_cnt - rd0, 0);
    check("bp_busy",   busy, 1);
    check("bp_no_dv",  beat_data.size() - base, 0);
    check("bp_port",   out_port, 3);
    drive_slot();
    port_rdy = 16'h0008;
    wait_frm("bp_done", 16'd2, 60);
    check("bp_beats", beat_data.size() - base, 5);
    check("bp_reads", rd_cnt - rd0, 5);
    if (beat_data.size() - base == 5) begin
      check("bp_first", beat_data[base], 8'hA0);
      check("bp_sof",   beat_sof[base], 1);
      check("bp_last",  beat_data[base+4], 8'hA4);
      check("bp_eof",   beat_eof[base+4], 1);
      check("bp_eof3",  beat_eof[base+3], 0);
    end

    // Rejected descriptors on the 2-port build: len 0, then port 3
    drive_slot();
    push_ptr_b(16'h2000);
    push_ptr_b(16'h3004);
    repeat (10) @(negedge clk);
    check("bad_err",   err_cnt_b, 2);
    check("bad_pops",  pop_cnt_b, 2);
    check("bad_no_rd", rd_cnt_b, 0);
    check("bad_frm",   frm_cnt_b, 0);
    check("bad_idle",  busy_b, 0);
    check("bad_dv",    out_dv_b, 0);

    // Error counter saturation: 300 more zero-length descriptors
    drive_slot();
    for (int i = 0; i < 300; i++) push_ptr_b(16'h0000);
    repeat (620) @(negedge clk);
    check("sat_err",  err_cnt_b, 8'hFF);
    check("sat_pops", pop_cnt_b, 302);
    check("sat_no_rd", rd_cnt_b, 0);

    // Back-to-back: 1-byte frame then 3-byte frame to port 0
    drive_slot();
    port_rdy = 16'h0001;
    push_dat(8'h55);
    push_dat(8'h66);
    push_dat(8'h67);
    push_dat(8'h68);
    push_ptr(16'h0001);
    push_ptr(16'h0003);
    base = beat_data.size();
    np   = pop_cyc.size();
    nr   = rd_start.size();
    ne   = eof_cyc.size();
    wait_frm("b2b_done", 16'd4, 80);
    check("b2b_pops",  pop_cyc.size() - np, 2);
    check("b2b_beats", beat_data.size() - base, 4);
    if (pop_cyc.size() - np == 2 && rd_start.size() - nr == 2 && eof_cyc.size() - ne == 2) begin
      check("b2b_pop_to_rd", rd_start[nr] - pop_cyc[np], 3);
      check("b2b_gap",       pop_cyc[np+1] - eof_cyc[ne], 3);
      check("b2b_period",    pop_cyc[np+1] - pop_cyc[np], 7);
    end else begin
      check("b2b_events", 0, 1);
    end
    if (beat_data.size() - base == 4) begin
      check("b2b_f1_data", beat_data[base], 8'h55);
      check("b2b_f1_sof",  beat_sof[base], 1);
      check("b2b_f1_eof",  beat_eof[base], 1);
      check("b2b_f2_sof",  beat_sof[base+1], 1);
      check("b2b_f2_data", beat_data[base+1], 8'h66);
      check("b2b_f2_mid",  beat_eof[base+2], 0);
      check("b2b_f2_eof",  beat_eof[base+3], 1);
      check("b2b_f2_last", beat_data[base+3], 8'h68);
    end
    repeat (5) @(negedge clk);

    // Mid-frame reset at byte 10 of a 34-byte frame, second descriptor queued
    drive_slot();
    port_rdy = 16'h0003;
    for (int i = 0; i < 34; i++) push_dat(8'h80 + 8'(i));
    push_ptr(16'h1022);
    push_ptr(16'h0002);
    base = beat_data.size();
    ne   = eof_cyc.size();
    n    = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      @(negedge clk);
      if (out_dv) n++;
    end
    check("mr_reach10", n, 10);
    rst = 1'b1;
    @(negedge clk);
    check("mr_dv",      out_dv, 0);
    check("mr_sof",     out_sof, 0);
    check("mr_eof",     out_eof, 0);
    check("mr_data",    out_data, 0);
    check("mr_port",    out_port, 0);
    check("mr_busy",    busy, 0);
    check("mr_data_rd", data_fifo_rd, 0);
    check("mr_ptr_rd",  ptr_fifo_rd, 0);
    check("mr_frm",     frm_cnt, 0);
    check("mr_beats",   beat_data.size() - base, 10);
    check("mr_no_eof",  eof_cyc.size() - ne, 0);
    drive_slot();
    rst = 1'b0;
    wait_frm("mr_next", 16'd1, 80);
    check("mr_next_beats", beat_data.size() - base, 12);
    if (beat_data.size() - base == 12) begin
      check("mr_next_b0",  beat_data[base+10], 8'h8A);
      check("mr_next_sof", beat_sof[base+10], 1);
      check("mr_next_b1",  beat_data[base+11], 8'h8B);
      check("mr_next_eof", beat_eof[base+11], 1);
    end
    check("mr_next_port", out_port, 0);
    repeat (5) @(negedge clk);
    check("mr_final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
